// File: rtl/axi_benes_burst_bridge_pkg.sv
// axi_benes_burst_bridge_pkg
// Shared definitions for the AXI-to-Benes burst bridge: AXI response and
// burst encodings, write/read FSM state types, and a burst-type helper.
package axi_benes_burst_bridge_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  // Only FIXED and INCR carry data; WRAP and the reserved code are rejected.
  function automatic logic burst_unsupported(input logic [1:0] burst);
    return !(burst == AXI_BURST_FIXED || burst == AXI_BURST_INCR);
  endfunction

endpackage

// File: rtl/benes_sync_fifo.sv
// benes_sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// pop_data whenever empty is low. A push while full and a pop while empty
// are ignored; simultaneous push and pop leaves the count unchanged.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset (flushes)
//   push, push_data, full push side
//   pop, pop_data, empty  pop side (pop_data is the current head)
//   count                 number of stored entries
module benes_sync_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_reg == FULL_CNT);
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr_reg];

  // Storage carries no reset; flushing only clears pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
      else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
    end
  end

endmodule

// File: rtl/axi_benes_burst_bridge.sv
// axi_benes_burst_bridge
// AXI4 burst slave bridging host bursts to and from the Benes network.
// Write beats are buffered in a FIFO and streamed out on bn_in_*; results
// arriving on bn_out_* are buffered and returned as AXI read beats.
// Optional feature macro: AXI_BENES_PERF_EN adds perf_wbeats/perf_rbeats
// (saturating counts of pushed W beats and popped R beats).
// Ports:
//   s00_axi_aclk, s00_axi_aresetn   clock, async active-low reset
//   s00_axi_aw*/w*/b*               AXI write address/data/response
//   s00_axi_ar*/r*                  AXI read address/data
//   bn_in_*                         valid/ready stream into the network
//   bn_out_*                        valid/ready stream from the network
module axi_benes_burst_bridge
  import axi_benes_burst_bridge_pkg::*;
#(
  parameter int C_S00_AXI_ID_WIDTH   = 1,
  parameter int C_S00_AXI_DATA_WIDTH = 512,
  parameter int C_S00_AXI_ADDR_WIDTH = 6,
  parameter int WFIFO_DEPTH          = 16,
  parameter int RFIFO_DEPTH          = 16
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_S00_AXI_ID_WIDTH-1:0]     s00_axi_awid,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [7:0]                        s00_axi_awlen,
  input  logic [2:0]                        s00_axi_awsize,
  input  logic [1:0]                        s00_axi_awburst,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wlast,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [C_S00_AXI_ID_WIDTH-1:0]     s00_axi_bid,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S00_AXI_ID_WIDTH-1:0]     s00_axi_arid,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [7:0]                        s00_axi_arlen,
  input  logic [2:0]                        s00_axi_arsize,
  input  logic [1:0]                        s00_axi_arburst,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S00_AXI_ID_WIDTH-1:0]     s00_axi_rid,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rlast,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   bn_in_data,
  output logic                              bn_in_valid,
  input  logic                              bn_in_ready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   bn_out_data,
  input  logic                              bn_out_valid,
  output logic                              bn_out_ready
`ifdef AXI_BENES_PERF_EN
  ,
  output logic [31:0]                       perf_wbeats,
  output logic [31:0]                       perf_rbeats
`endif
);

  localparam int DW = C_S00_AXI_DATA_WIDTH;
  localparam int IW = C_S00_AXI_ID_WIDTH;

  // ---------------- FIFOs ----------------
  logic                       wfifo_push, wfifo_full, wfifo_empty;
  logic                       rfifo_push, rfifo_pop, rfifo_full, rfifo_empty;
  logic [DW-1:0]              rfifo_head;
  logic [$clog2(WFIFO_DEPTH):0] wfifo_count;
  logic [$clog2(RFIFO_DEPTH):0] rfifo_count;

  benes_sync_fifo #(.WIDTH(DW), .DEPTH(WFIFO_DEPTH)) u_wfifo (
    .clk(s00_axi_aclk), .rst_n(s00_axi_aresetn),
    .push(wfifo_push), .push_data(s00_axi_wdata), .full(wfifo_full),
    .pop(bn_in_valid && bn_in_ready), .pop_data(bn_in_data),
    .empty(wfifo_empty), .count(wfifo_count)
  );

  benes_sync_fifo #(.WIDTH(DW), .DEPTH(RFIFO_DEPTH)) u_rfifo (
    .clk(s00_axi_aclk), .rst_n(s00_axi_aresetn),
    .push(rfifo_push), .push_data(bn_out_data), .full(rfifo_full),
    .pop(rfifo_pop), .pop_data(rfifo_head),
    .empty(rfifo_empty), .count(rfifo_count)
  );

  assign bn_in_valid  = !wfifo_empty;
  assign bn_out_ready = !rfifo_full;
  assign rfifo_push   = bn_out_valid && bn_out_ready;

  // Address, size and FIFO fill levels are intentionally not used.
  logic unused_ok;
  assign unused_ok = ^{s00_axi_awaddr, s00_axi_awsize, s00_axi_araddr,
                       s00_axi_arsize, wfifo_count, rfifo_count};

  // Holds address-ready low until the first clock edge after reset release.
  logic ready_en_reg;

  // ---------------- State ----------------
  w_state_t      w_state_reg, w_state_next;
  logic [IW-1:0] aw_id_reg, aw_id_next;
  logic [7:0]    aw_len_reg, aw_len_next;
  logic          aw_bad_reg, aw_bad_next;
  logic [7:0]    w_cnt_reg, w_cnt_next;
  logic          w_err_reg, w_err_next;

  r_state_t      r_state_reg, r_state_next;
  logic [IW-1:0] ar_id_reg, ar_id_next;
  logic [7:0]    ar_len_reg, ar_len_next;
  logic          ar_bad_reg, ar_bad_next;
  logic [7:0]    r_cnt_reg, r_cnt_next;

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      ready_en_reg <= 1'b0;
      w_state_reg  <= W_IDLE;
      aw_id_reg    <= '0;
      aw_len_reg   <= '0;
      aw_bad_reg   <= 1'b0;
      w_cnt_reg    <= '0;
      w_err_reg    <= 1'b0;
      r_state_reg  <= R_IDLE;
      ar_id_reg    <= '0;
      ar_len_reg   <= '0;
      ar_bad_reg   <= 1'b0;
      r_cnt_reg    <= '0;
    end else begin
      ready_en_reg <= 1'b1;
      w_state_reg  <= w_state_next;
      aw_id_reg    <= aw_id_next;
      aw_len_reg   <= aw_len_next;
      aw_bad_reg   <= aw_bad_next;
      w_cnt_reg    <= w_cnt_next;
      w_err_reg    <= w_err_next;
      r_state_reg  <= r_state_next;
      ar_id_reg    <= ar_id_next;
      ar_len_reg   <= ar_len_next;
      ar_bad_reg   <= ar_bad_next;
      r_cnt_reg    <= r_cnt_next;
    end
  end

  // ---------------- Write FSM ----------------
  logic w_last_beat;
  assign w_last_beat = (w_cnt_reg == aw_len_reg);
  assign s00_axi_bid = aw_id_reg;

  always_comb begin
    w_state_next    = w_state_reg;
    aw_id_next      = aw_id_reg;
    aw_len_next     = aw_len_reg;
    aw_bad_next     = aw_bad_reg;
    w_cnt_next      = w_cnt_reg;
    w_err_next      = w_err_reg;
    s00_axi_awready = 1'b0;
    s00_axi_wready  = 1'b0;
    s00_axi_bvalid  = 1'b0;
    s00_axi_bresp   = AXI_RESP_OKAY;
    wfifo_push      = 1'b0;
    case (w_state_reg)
      W_IDLE: begin
        s00_axi_awready = ready_en_reg;
        if (s00_axi_awvalid && ready_en_reg) begin
          aw_id_next   = s00_axi_awid;
          aw_len_next  = s00_axi_awlen;
          aw_bad_next  = burst_unsupported(s00_axi_awburst);
          w_err_next   = burst_unsupported(s00_axi_awburst);
          w_cnt_next   = '0;
          w_state_next = W_DATA;
        end
      end
      W_DATA: begin
        // Unsupported bursts are drained without touching the FIFO.
        s00_axi_wready = aw_bad_reg || !wfifo_full;
        if (s00_axi_wvalid && (aw_bad_reg || !wfifo_full)) begin
          wfifo_push = !aw_bad_reg;
          if (!(&s00_axi_wstrb) || (s00_axi_wlast != w_last_beat)) begin
            w_err_next = 1'b1;
          end
          if (w_last_beat) w_state_next = W_RESP;
          else             w_cnt_next   = w_cnt_reg + 8'd1;
        end
      end
      W_RESP: begin
        s00_axi_bvalid = 1'b1;
        s00_axi_bresp  = w_err_reg ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        if (s00_axi_bready) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  // ---------------- Read FSM ----------------
  assign s00_axi_rid = ar_id_reg;

  always_comb begin
    r_state_next    = r_state_reg;
    ar_id_next      = ar_id_reg;
    ar_len_next     = ar_len_reg;
    ar_bad_next     = ar_bad_reg;
    r_cnt_next      = r_cnt_reg;
    s00_axi_arready = 1'b0;
    s00_axi_rvalid  = 1'b0;
    s00_axi_rdata   = '0;
    s00_axi_rresp   = AXI_RESP_OKAY;
    s00_axi_rlast   = 1'b0;
    rfifo_pop       = 1'b0;
    if (r_state_reg == R_IDLE) begin
      s00_axi_arready = ready_en_reg;
      if (s00_axi_arvalid && ready_en_reg) begin
        ar_id_next   = s00_axi_arid;
        ar_len_next  = s00_axi_arlen;
        ar_bad_next  = burst_unsupported(s00_axi_arburst);
        r_cnt_next   = '0;
        r_state_next = R_DATA;
      end
    end else begin
      if (ar_bad_reg) begin
        // Error beats are synthesised locally; the result FIFO is untouched.
        s00_axi_rvalid = 1'b1;
        s00_axi_rresp  = AXI_RESP_SLVERR;
      end else begin
        s00_axi_rvalid = !rfifo_empty;
        s00_axi_rdata  = rfifo_empty ? '0 : rfifo_head;
      end
      s00_axi_rlast = s00_axi_rvalid && (r_cnt_reg == ar_len_reg);
      if (s00_axi_rvalid && s00_axi_rready) begin
        rfifo_pop = !ar_bad_reg;
        if (r_cnt_reg == ar_len_reg) r_state_next = R_IDLE;
        else                         r_cnt_next   = r_cnt_reg + 8'd1;
      end
    end
  end

`ifdef AXI_BENES_PERF_EN
  // ---------------- Saturating beat counters ----------------
  logic [31:0] perf_wbeats_reg, perf_rbeats_reg;

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      perf_wbeats_reg <= '0;
      perf_rbeats_reg <= '0;
    end else begin
      if (wfifo_push && (perf_wbeats_reg != '1)) perf_wbeats_reg <= perf_wbeats_reg + 32'd1;
      if (rfifo_pop && (perf_rbeats_reg != '1))  perf_rbeats_reg <= perf_rbeats_reg + 32'd1;
    end
  end

  assign perf_wbeats = perf_wbeats_reg;
  assign perf_rbeats = perf_rbeats_reg;
`endif

endmodule

// File: doc/axi_benes_burst_bridge.md
# axi_benes_burst_bridge

AXI4 burst slave that bridges host bursts to and from the Benes interconnect. Write bursts are buffered in a write FIFO and streamed into the Benes network as valid/ready beats. Read bursts drain a result FIFO fed by the network's output stream. It is the buffered, parametrised successor to the plain AXI slave shim in the interconnect sim path, and adds burst-type checking and error responses.

## Interface
- C_S00_AXI_ID_WIDTH, 1, AXI ID width
- C_S00_AXI_DATA_WIDTH, 512, beat width; equals $bits of the Benes input/output typedefs
- C_S00_AXI_ADDR_WIDTH, 6, address width; address is accepted but not decoded
- WFIFO_DEPTH, 16, write FIFO entries, power of two, ≥2
- RFIFO_DEPTH, 16, result FIFO entries, power of two, ≥2

Ports:
- s00_axi_aclk  in  1  single clock
- s00_axi_aresetn  in  1  asynchronous, active-low reset
- s00_axi_aw{id,addr,len[8],size[3],burst[2],valid} in / s00_axi_awready out  AW channel
- s00_axi_wdata in DATA, s00_axi_wstrb in DATA/8, s00_axi_wlast/wvalid in, s00_axi_wready out  W channel
- s00_axi_bid out ID, s00_axi_bresp out 2, s00_axi_bvalid out, s00_axi_bready in  B channel
- s00_axi_ar{id,addr,len,size,burst,valid} in / s00_axi_arready out  AR channel
- s00_axi_rid out ID, s00_axi_rdata out DATA, s00_axi_rresp out 2, s00_axi_rlast/rvalid out, s00_axi_rready in  R channel
- bn_in_data out DATA, bn_in_valid out 1, bn_in_ready in 1  stream to the Benes network
- bn_out_data in DATA, bn_out_valid in 1, bn_out_ready out 1  stream from the Benes network
- AXI lock/cache/prot/qos/region/user signals are not ported.

## Operation
- Write FSM W_IDLE→W_DATA→W_RESP→W_IDLE. W_IDLE: awready=1; an AW handshake captures id, len and burst. W_DATA: wready=!wfifo_full; each W handshake pushes wdata and increments beat_cnt. The transfer with beat_cnt==awlen moves the FSM to W_RESP. W_RESP: bvalid=1 with the captured bid; a B handshake returns to W_IDLE.
- bresp=SLVERR (2'b10) if any beat has wstrb not all-ones, if wlast is inconsistent with beat_cnt==awlen, or if awburst is WRAP or reserved. Otherwise bresp=OKAY. For WRAP/reserved bursts, beats are accepted with wready=1 and discarded without a push.
- Read FSM R_IDLE→R_DATA→R_IDLE. R_IDLE: arready=1; an AR handshake captures id, len and burst. R_DATA: rvalid=!rfifo_empty, rdata=FIFO head, rlast=(beat_cnt==arlen), rresp=OKAY; each R handshake pops one entry. For WRAP/reserved bursts: rvalid=1 every cycle, rdata=0, rresp=SLVERR, no pop.
- awsize/arsize are ignored; every beat is a full DATA-width word. FIXED and INCR bursts are handled identically.
- Benes side: bn_in_valid=!wfifo_empty, bn_in_data=write FIFO head; bn_out_ready=!rfifo_full.
- FIFOs are first-word fall-through. A simultaneous push and pop leaves the count unchanged. A full FIFO deasserts its push-side ready even if a pop occurs in the same cycle.
- rdata is driven to 0 whenever rvalid is low.

## Timing
- Reset (async assert): both FSMs go idle, FIFOs flush, and beat counters clear. awready/arready read 0 while reset is asserted and go to 1 on the first clock edge after release. All valids, resps, ids and rlast reset to 0.
- Reset mid-burst abandons the burst: no B or R completion, buffered data is lost.
- AW handshake at cycle T → wready is 1 at T+1 at the earliest.
- A W beat accepted at T → appears on bn_in_data/bn_in_valid at T+1.
- Last W beat at T → bvalid at T+1.
- AR handshake at T → rvalid at T+1 at the earliest, if the result FIFO is non-empty.
- Result beat accepted on bn_out at T → visible on rdata at T+1.
- Write and read paths are fully independent and run concurrently.

## Configuration
- AXI_BENES_PERF_EN defined: adds output ports perf_wbeats and perf_rbeats, each 32 bits, reset to 0. They are saturating counts of pushed W beats and popped R beats.
- Without AXI_BENES_PERF_EN: the ports and counters do not exist.

## Structure
- The shared package holds AXI_RESP_OKAY/AXI_RESP_SLVERR, AXI_BURST_FIXED/INCR/WRAP constants, and the write/read FSM state enums.
- One sub-module: benes_sync_fifo, parametrised by width and depth. It is instantiated twice and provides push/pop/full/empty/count.

## Test plan
- Single-beat INCR: awlen=0, wdata=0xA5.., bn_in_ready=1 → bn_in_valid at T+1 with 0xA5.., then bresp=OKAY, bid echoes awid=1.
- 20-beat INCR write with WFIFO_DEPTH=16 and bn_in_ready=0 → wready drops after 16 beats. Releasing bn_in_ready completes all 20 beats in order, then OKAY.
- 4-beat read while the result FIFO holds 2 beats → 2 beats returned, rvalid stalls low, next bn_out beats resume. rlast only on beat 4.
- WRAP write with awlen=3 → 4 beats accepted, no bn_in_valid, bresp=SLVERR. WRAP read with arlen=1 → 2 zero beats, rresp=SLVERR.
- Write beat with wstrb=0x0F.. → data pushed, bresp=SLVERR.
- Assert s00_axi_aresetn low mid-burst (beat 2 of 8) → all outputs at reset values, FIFOs empty, no bvalid after release.
